recwind_writer: RTL
===================

RECWIND_WRITER -- requirements
Module: recwind_writer

Interface
REQ-001 Parameters: DATA_WIDTH, default 64, datapath width; CTRL_WIDTH, default DATA_WIDTH/8, ctrl width; UDP_REG_SRC_WIDTH, default 2, register source tag width.
REQ-002 clk  in  1  single clock; all logic in this domain.
REQ-003 reset  in  1  asynchronous, active-low reset (block held in reset while 0).
REQ-004 in_data/in_ctrl/in_wr  in  DATA_WIDTH/CTRL_WIDTH/1  upstream packet words; in_rdy  out  1  upstream may write when 1.
REQ-005 out_data/out_ctrl/out_wr  out  DATA_WIDTH/CTRL_WIDTH/1  downstream words; out_rdy  in  1  downstream accepts when 1.
REQ-006 reg_req/ack/rd_wr_L/addr/data/src _in and _out  standard UDP register ring, widths `UDP_REG_ADDR_WIDTH, `CPCI_NF2_DATA_WIDTH, UDP_REG_SRC_WIDTH; block tag `RECWIND_WRITER_BLOCK_ADDR.
REQ-007 Software regs: SW0 bit0 = enable; SW1 [15:0] = max_wind; both reset to 0.

Function
REQ-008 Input buffered in a 4-deep fall-through FIFO; in_rdy = !nearly_full.
REQ-009 Word read from FIFO only when FIFO non-empty and out_rdy=1; output stage registered, latency exactly 1 cycle; out_wr pulses once per word read; no word dropped, duplicated or reordered.
REQ-010 Word numbering: words with in_ctrl!=0 before first ctrl==0 word are module headers (passed unmodified); first ctrl==0 word is word 1.
REQ-011 FSM states: MOD_HDRS, HDRS (words 1-6), WIND (word 7), PASS (rest to EOP).
REQ-012 MOD_HDRS -> HDRS on first ctrl==0 word; HDRS -> WIND after word 6; WIND -> PASS after word 7; PASS -> MOD_HDRS on word with ctrl!=0 (EOP).
REQ-013 Qualify flag cleared at word 1; set false if word 2 [31:16]!=16'h0800, word 2 [15:12]!=4'h4, word 2 [11:8]!=4'h5 (IP options unsupported), or word 3 [7:0]!=8'h06.
REQ-014 Word 7: window m = [63:48], TCP checksum HC = [47:32]; rewrite iff qualified && enable && m > max_wind.
REQ-015 Rewrite: [63:48] <= max_wind; [47:32] <= ~(~HC + ~m + max_wind), 16-bit one's-complement sum with end-around carries (RFC 1624); all other bits unchanged.
REQ-016 enable and max_wind sampled in the cycle word 7 is read; register changes never alter an in-flight word.
REQ-017 EOP (ctrl!=0) before word 7: packet passed unmodified, FSM -> MOD_HDRS, counter unchanged.
REQ-018 Non-qualifying, disabled or m<=max_wind packets: every byte passed unmodified.
REQ-019 Back-to-back packets: EOP and next module header on consecutive cycles handled with no bubble.

Reset
REQ-020 While reset=0: out_wr=0, out_data=0, out_ctrl=0, FSM=MOD_HDRS, word count=0, FIFO empty, SW regs=0, counter=0.
REQ-021 Reset mid-packet discards the partial packet; first word after release is treated as a module header.

Configuration
REQ-022 Macro RECWIND_WRITER_CNT_EN defined: one 32-bit hardware register counts rewritten packets, +1 per rewrite, wraps 0xFFFFFFFF->0.
REQ-023 Macro undefined: no counter, zero hardware registers; datapath behaviour identical.

Verification
REQ-024 TCP packet, window 16'hFFFF, HC 16'h1234, enable=1, max_wind 16'h1000 -> word 7 [63:32] = 32'h1000_0234, other words identical, counter=1.
REQ-025 Same packet, window 16'h0800 -> output identical to input, counter unchanged.
REQ-026 UDP (proto 8'h11) or IHL=6 packet, window 16'hFFFF -> output identical to input.
REQ-027 Packet with EOP on word 4, then a valid TCP packet back-to-back -> first unmodified, second rewritten per REQ-024.
REQ-028 out_rdy=0 for 3 cycles while word 7 at FIFO head -> no out_wr during stall, rewritten word 7 emitted once after out_rdy=1.
REQ-029 reset=0 asserted at word 5, released, full TCP packet sent -> only second packet appears, correctly rewritten.

Source files
------------

// File: rtl/recwind_writer_if.sv
// ---------------------------------------------------------------------------
// recwind_writer_if
//   Bundles the packet stream and UDP register ring signals of
//   recwind_writer.
//
//   Packet input  : in_data, in_ctrl, in_wr (to block), in_rdy (from block)
//   Packet output : out_data, out_ctrl, out_wr (from block), out_rdy (to block)
//   Register ring : reg_{req,ack,rd_wr_L,addr,data,src}_in  (to block)
//                   reg_{req,ack,rd_wr_L,addr,data,src}_out (from block)
//
//   Modports:
//     master - upstream/testbench side, drives the block inputs
//     slave  - the recwind_writer side
//
//   Ring widths come from `UDP_REG_ADDR_WIDTH and `CPCI_NF2_DATA_WIDTH.
//   Defaults are supplied here when the surrounding project has not
//   already defined them. The block claims ring addresses whose upper
//   bits equal `RECWIND_WRITER_BLOCK_ADDR.
// ---------------------------------------------------------------------------
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif
`ifndef RECWIND_WRITER_REG_ADDR_WIDTH
`define RECWIND_WRITER_REG_ADDR_WIDTH 6
`endif
`ifndef RECWIND_WRITER_BLOCK_ADDR
`define RECWIND_WRITER_BLOCK_ADDR 17'h000A5
`endif

interface recwind_writer_if #(
    parameter int DATA_WIDTH        = 64,
    parameter int CTRL_WIDTH        = DATA_WIDTH/8,
    parameter int UDP_REG_SRC_WIDTH = 2
) ();

    logic [DATA_WIDTH-1:0]             in_data;
    logic [CTRL_WIDTH-1:0]             in_ctrl;
    logic                              in_wr;
    logic                              in_rdy;

    logic [DATA_WIDTH-1:0]             out_data;
    logic [CTRL_WIDTH-1:0]             out_ctrl;
    logic                              out_wr;
    logic                              out_rdy;

    logic                              reg_req_in;
    logic                              reg_ack_in;
    logic                              reg_rd_wr_L_in;
    logic [`UDP_REG_ADDR_WIDTH-1:0]    reg_addr_in;
    logic [`CPCI_NF2_DATA_WIDTH-1:0]   reg_data_in;
    logic [UDP_REG_SRC_WIDTH-1:0]      reg_src_in;

    logic                              reg_req_out;
    logic                              reg_ack_out;
    logic                              reg_rd_wr_L_out;
    logic [`UDP_REG_ADDR_WIDTH-1:0]    reg_addr_out;
    logic [`CPCI_NF2_DATA_WIDTH-1:0]   reg_data_out;
    logic [UDP_REG_SRC_WIDTH-1:0]      reg_src_out;

    modport master (
        output in_data, in_ctrl, in_wr, out_rdy,
        output reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in,
        input  in_rdy, out_data, out_ctrl, out_wr,
        input  reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out
    );

    modport slave (
        input  in_data, in_ctrl, in_wr, out_rdy,
        input  reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in,
        output in_rdy, out_data, out_ctrl, out_wr,
        output reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out
    );

endinterface

// File: rtl/recwind_writer.sv
// ---------------------------------------------------------------------------
// recwind_writer
//   Clamps the TCP receive window of passing IPv4/TCP packets (no IP
//   options) to a software-programmed maximum, patching the TCP checksum
//   incrementally. Everything else passes through untouched.
//
//   Ports:
//     clk    - single clock
//     reset  - asynchronous, active-low
//     bus    - recwind_writer_if.slave: packet in/out streams and the UDP
//              register ring
//
//   Register map (low address bits inside this block's ring window):
//     0 SW0 : bit0 = enable
//     1 SW1 : [15:0] = max_wind
//     2 HW  : rewritten packet count (only with RECWIND_WRITER_CNT_EN)
//
//   Optional build macro:
//     RECWIND_WRITER_CNT_EN - adds a 32-bit wrapping count of rewritten
//                             packets. Without it the block has no hardware
//                             registers; the datapath is identical.
//
//   Packet words: words with ctrl!=0 ahead of the first ctrl==0 word are
//   module headers. The first ctrl==0 word is word 1. Words 2 and 3 carry
//   ethertype/version/IHL and the IP protocol. Word 7 [63:48] holds the
//   window and word 7 [47:32] the TCP checksum.
// ---------------------------------------------------------------------------
module recwind_writer #(
    parameter int DATA_WIDTH        = 64,
    parameter int CTRL_WIDTH        = DATA_WIDTH/8,
    parameter int UDP_REG_SRC_WIDTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    recwind_writer_if.slave bus
);

    localparam int FIFO_DEPTH = 4;
    localparam int WORD_W     = CTRL_WIDTH + DATA_WIDTH;
    localparam int REG_DATA_W = `CPCI_NF2_DATA_WIDTH;
    localparam int REG_ADDR_W = `UDP_REG_ADDR_WIDTH;
    localparam int REG_IDX_W  = `RECWIND_WRITER_REG_ADDR_WIDTH;

    localparam logic [REG_IDX_W-1:0] REG_SW0 = REG_IDX_W'(0);
    localparam logic [REG_IDX_W-1:0] REG_SW1 = REG_IDX_W'(1);
`ifdef RECWIND_WRITER_CNT_EN
    localparam logic [REG_IDX_W-1:0] REG_CNT = REG_IDX_W'(2);
`endif

    typedef enum logic [1:0] {
        MOD_HDRS = 2'd0,
        HDRS     = 2'd1,
        WIND     = 2'd2,
        PASS     = 2'd3
    } state_t;

    // RFC 1624 incremental update: HC' = ~(~HC + ~m + m'), 16-bit one's
    // complement arithmetic. Two folds absorb every end-around carry.
    function automatic logic [15:0] csum_adjust(
        input logic [15:0] hc,
        input logic [15:0] m_old,
        input logic [15:0] m_new
    );
        logic [17:0] sum;
        sum = {2'b00, ~hc} + {2'b00, ~m_old} + {2'b00, m_new};
        sum = {2'b00, sum[15:0]} + {16'b0, sum[17:16]};
        sum = {2'b00, sum[15:0]} + {16'b0, sum[17:16]};
        return ~sum[15:0];
    endfunction

    // Software registers
    logic        sw_enable;
    logic [15:0] sw_max_wind;

    // ------------------------------------------------------------------
    // Stage p0: 4-deep fall-through FIFO, head word visible combinationally
    // ------------------------------------------------------------------
    logic [WORD_W-1:0]     fifo_mem [FIFO_DEPTH];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [2:0]            fifo_cnt;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  nearly_full;
    logic                  fifo_wr;
    logic                  vld_p0;
    logic [DATA_WIDTH-1:0] head_data_p0;
    logic [CTRL_WIDTH-1:0] head_ctrl_p0;

    assign fifo_empty  = (fifo_cnt == 3'd0);
    assign fifo_full   = (fifo_cnt == 3'd4);
    // One slot of slack so a write launched against in_rdy=1 always fits.
    assign nearly_full = (fifo_cnt >= 3'd3);
    assign bus.in_rdy  = !nearly_full;
    assign fifo_wr     = bus.in_wr && !fifo_full;
    assign vld_p0      = !fifo_empty && bus.out_rdy;

    assign head_data_p0 = fifo_mem[rd_ptr][DATA_WIDTH-1:0];
    assign head_ctrl_p0 = fifo_mem[rd_ptr][WORD_W-1:DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr] <= {bus.in_ctrl, bus.in_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            fifo_cnt <= 3'd0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (vld_p0) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({fifo_wr, vld_p0})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Packet parsing state
    state_t      state;
    logic [2:0]  word_cnt;
    logic        qual;

    logic [15:0]           wind_m;
    logic [15:0]           wind_hc;
    logic                  ip_ok;
    logic                  do_rewrite;
    logic [DATA_WIDTH-1:0] word_p0;

    assign wind_m  = head_data_p0[63:48];
    assign wind_hc = head_data_p0[47:32];
    assign ip_ok   = (head_data_p0[31:16] == 16'h0800) &&
                     (head_data_p0[15:12] == 4'h4) &&
                     (head_data_p0[11:8]  == 4'h5);

    // enable/max_wind are used live in the cycle word 7 leaves the FIFO,
    // so a later register write cannot touch a word already emitted.
    assign do_rewrite = (state == WIND) && qual && sw_enable &&
                        (wind_m > sw_max_wind);

    always_comb begin
        word_p0 = head_data_p0;
        if (do_rewrite) begin
            word_p0[63:48] = sw_max_wind;
            word_p0[47:32] = csum_adjust(wind_hc, wind_m, sw_max_wind);
        end
    end

    // ------------------------------------------------------------------
    // Stage p1: FSM and registered output word
    // ------------------------------------------------------------------
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] out_data_p1;
    logic [CTRL_WIDTH-1:0] out_ctrl_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= MOD_HDRS;
            word_cnt    <= 3'd0;
            qual        <= 1'b0;
            vld_p1      <= 1'b0;
            out_data_p1 <= '0;
            out_ctrl_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                out_data_p1 <= word_p0;
                out_ctrl_p1 <= head_ctrl_p0;
                case (state)
                    MOD_HDRS: begin
                        if (head_ctrl_p0 == '0) begin
                            state    <= HDRS;
                            word_cnt <= 3'd1;
                            qual     <= 1'b1;
                        end
                    end
                    HDRS: begin
                        if (head_ctrl_p0 != '0) begin
                            // Short packet: EOP before the window word.
                            state    <= MOD_HDRS;
                            word_cnt <= 3'd0;
                        end else begin
                            word_cnt <= word_cnt + 3'd1;
                            if (word_cnt == 3'd1 && !ip_ok) begin
                                qual <= 1'b0;
                            end
                            if (word_cnt == 3'd2 && head_data_p0[7:0] != 8'h06) begin
                                qual <= 1'b0;
                            end
                            if (word_cnt == 3'd5) begin
                                state <= WIND;
                            end
                        end
                    end
                    WIND: begin
                        if (head_ctrl_p0 != '0) begin
                            state    <= MOD_HDRS;
                            word_cnt <= 3'd0;
                        end else begin
                            state    <= PASS;
                            word_cnt <= 3'd7;
                        end
                    end
                    PASS: begin
                        if (head_ctrl_p0 != '0) begin
                            state    <= MOD_HDRS;
                            word_cnt <= 3'd0;
                        end
                    end
                    default: begin
                        state    <= MOD_HDRS;
                        word_cnt <= 3'd0;
                    end
                endcase
            end
        end
    end

    assign bus.out_wr   = vld_p1;
    assign bus.out_data = out_data_p1;
    assign bus.out_ctrl = out_ctrl_p1;

`ifdef RECWIND_WRITER_CNT_EN
    logic [31:0] rewrite_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rewrite_cnt <= 32'd0;
        end else if (vld_p0 && do_rewrite) begin
            rewrite_cnt <= rewrite_cnt + 32'd1;
        end
    end
`endif

    // Register ring: a request for this block that nobody has acked yet is
    // answered here; everything else is forwarded one cycle later.
    logic                  blk_hit;
    logic [REG_IDX_W-1:0]  reg_idx;
    logic [REG_DATA_W-1:0] reg_rd_val;

    logic                          reg_req_q;
    logic                          reg_ack_q;
    logic                          reg_rd_wr_L_q;
    logic [REG_ADDR_W-1:0]         reg_addr_q;
    logic [REG_DATA_W-1:0]         reg_data_q;
    logic [UDP_REG_SRC_WIDTH-1:0]  reg_src_q;

    assign reg_idx = bus.reg_addr_in[REG_IDX_W-1:0];
    assign blk_hit = bus.reg_req_in && !bus.reg_ack_in &&
                     (bus.reg_addr_in[REG_ADDR_W-1:REG_IDX_W] == `RECWIND_WRITER_BLOCK_ADDR);

    always_comb begin
        reg_rd_val = '0;
        case (reg_idx)
            REG_SW0: reg_rd_val[0]    = sw_enable;
            REG_SW1: reg_rd_val[15:0] = sw_max_wind;
`ifdef RECWIND_WRITER_CNT_EN
            REG_CNT: reg_rd_val[31:0] = rewrite_cnt;
`endif
            default: reg_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_enable     <= 1'b0;
            sw_max_wind   <= 16'd0;
            reg_req_q     <= 1'b0;
            reg_ack_q     <= 1'b0;
            reg_rd_wr_L_q <= 1'b0;
            reg_addr_q    <= '0;
            reg_data_q    <= '0;
            reg_src_q     <= '0;
        end else begin
            reg_req_q     <= bus.reg_req_in;
            reg_rd_wr_L_q <= bus.reg_rd_wr_L_in;
            reg_addr_q    <= bus.reg_addr_in;
            reg_src_q     <= bus.reg_src_in;
            if (blk_hit) begin
                reg_ack_q  <= 1'b1;
                reg_data_q <= bus.reg_rd_wr_L_in ? reg_rd_val : bus.reg_data_in;
                if (!bus.reg_rd_wr_L_in) begin
                    case (reg_idx)
                        REG_SW0: sw_enable   <= bus.reg_data_in[0];
                        REG_SW1: sw_max_wind <= bus.reg_data_in[15:0];
                        default: ;
                    endcase
                end
            end else begin
                reg_ack_q  <= bus.reg_ack_in;
                reg_data_q <= bus.reg_data_in;
            end
        end
    end

    assign bus.reg_req_out     = reg_req_q;
    assign bus.reg_ack_out     = reg_ack_q;
    assign bus.reg_rd_wr_L_out = reg_rd_wr_L_q;
    assign bus.reg_addr_out    = reg_addr_q;
    assign bus.reg_data_out    = reg_data_q;
    assign bus.reg_src_out     = reg_src_q;

endmodule
